// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the branch predictor: PC slicing, direction
// counter constants and the saturating increment/decrement used by both the
// direction counters and the 32-bit statistics counters.
package branch_predictor_pkg;

  // Operation applied to a direction counter in one cycle.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_LOAD = 2'd3
  } cnt_op_e;

  // Weakly-taken value for a counter of the given width (MSB set, rest clear).
  function automatic logic [31:0] cnt_weak_t(int cnt_w);
    return 32'd1 << (cnt_w - 1);
  endfunction

  // Weakly-not-taken value: one below weakly-taken.
  function automatic logic [31:0] cnt_weak_nt(int cnt_w);
    return cnt_weak_t(cnt_w) - 32'd1;
  endfunction

  // BTB index: word-aligned PC bits just above the byte offset.
  function automatic logic [31:0] pc_index(logic [63:0] pc, int idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return 32'((pc >> 2) & mask);
  endfunction

  // BTB tag: the TAG_W bits immediately above the index.
  function automatic logic [31:0] pc_tag(logic [63:0] pc, int idx_w, int tag_w);
    logic [63:0] mask;
    mask = (64'd1 << tag_w) - 64'd1;
    return 32'((pc >> (idx_w + 2)) & mask);
  endfunction

  // Increment that sticks at max instead of wrapping.
  function automatic logic [31:0] sat_inc(logic [31:0] v, logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

  // Decrement that sticks at zero instead of wrapping.
  function automatic logic [31:0] sat_dec(logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// sat_counter: W-bit saturating up/down counter with parallel load, used as
// the per-entry branch direction counter. W must not exceed 32.
module branch_predictor_sat_counter
  import branch_predictor_pkg::*;
#(
  parameter int         W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  cnt_op_e      op_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [31:0] MAX = 32'((64'd1 << W) - 64'd1);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: hold, saturating step up/down, or load.
  always_comb begin
    cnt_d = cnt_q;
    unique case (op_i)
      CNT_INC:  cnt_d = W'(sat_inc(32'(cnt_q), MAX));
      CNT_DEC:  cnt_d = W'(sat_dec(32'(cnt_q)));
      CNT_LOAD: cnt_d = load_val_i;
      default:  cnt_d = cnt_q;
    endcase
  end

  // Counter register, returns to RST_VAL on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= RST_VAL;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with per-entry saturating
// direction counters. Looked up combinationally from the IF PC, trained with
// resolved outcomes from ID, and reports mispredicts plus the correct PC.
// DATA_W is limited to 64 by the PC slicing helpers.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable,
  input  logic              clear,
  input  logic [DATA_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [DATA_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [DATA_W-1:0] upd_pc,
  input  logic              upd_is_jump,
  input  logic              upd_taken,
  input  logic [DATA_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [DATA_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [31:0]       branch_cnt,
  output logic [31:0]       mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(cnt_weak_t(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'(cnt_weak_nt(CNT_W));
  localparam logic [31:0]      STAT_MAX    = 32'hFFFF_FFFF;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] target;
    logic              is_jump;
  } entry_t;

  entry_t           entry_q [ENTRIES];
  entry_t           entry_d [ENTRIES];
  logic [CNT_W-1:0] cnt     [ENTRIES];
  cnt_op_e          cnt_op  [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  entry_t           lk_entry, up_entry;
  logic             up_hit, upd_en, stat_en;
  logic [31:0]      branch_cnt_d, branch_cnt_q, mispred_cnt_d, mispred_cnt_q;

  assign lk_idx   = IDX_W'(pc_index(64'(lookup_pc), IDX_W));
  assign lk_tag   = TAG_W'(pc_tag(64'(lookup_pc), IDX_W, TAG_W));
  assign up_idx   = IDX_W'(pc_index(64'(upd_pc), IDX_W));
  assign up_tag   = TAG_W'(pc_tag(64'(upd_pc), IDX_W, TAG_W));
  assign lk_entry = entry_q[lk_idx];
  assign up_entry = entry_q[up_idx];

  // Lookup reads registered state only, so a same-cycle update is not seen.
  assign pred_hit    = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign pred_taken  = pred_hit && (lk_entry.is_jump || (cnt[lk_idx] >= CNT_WEAK_T));
  assign pred_target = pred_taken ? lk_entry.target : lookup_pc + DATA_W'(4);

  // Resolution check is purely combinational and ignores enable.
  assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                     (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + DATA_W'(4);

  assign upd_en  = enable && upd_valid && !clear;
  assign up_hit  = up_entry.valid && (up_entry.tag == up_tag);
  assign stat_en = enable && upd_valid;

  // Next BTB contents and direction-counter operations; clear beats update.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      entry_d[i] = entry_q[i];
      cnt_op[i]  = CNT_HOLD;
    end
    if (enable && clear) begin
      for (int i = 0; i < ENTRIES; i++) entry_d[i].valid = 1'b0;
    end else if (upd_en) begin
      if (up_hit) begin
        cnt_op[up_idx] = upd_taken ? CNT_INC : CNT_DEC;
        if (upd_taken) begin
          entry_d[up_idx].target  = upd_target;
          entry_d[up_idx].is_jump = upd_is_jump;
        end
      end else if (upd_taken) begin
        entry_d[up_idx].valid   = 1'b1;
        entry_d[up_idx].tag     = up_tag;
        entry_d[up_idx].target  = upd_target;
        entry_d[up_idx].is_jump = upd_is_jump;
        cnt_op[up_idx]          = CNT_LOAD;
      end
    end
  end

  // BTB entry registers, frozen while enable is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) entry_q[i] <= '0;
    end else if (enable) begin
      for (int i = 0; i < ENTRIES; i++) entry_q[i] <= entry_d[i];
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_dir
    branch_predictor_sat_counter #(
      .W       (CNT_W),
      .RST_VAL (CNT_WEAK_NT)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .op_i       (cnt_op[g]),
      .load_val_i (CNT_WEAK_T),
      .cnt_o      (cnt[g])
    );
  end

  // Next statistics values, saturating at all-ones.
  always_comb begin
    branch_cnt_d  = stat_en ? sat_inc(branch_cnt_q, STAT_MAX) : branch_cnt_q;
    mispred_cnt_d = (stat_en && mispredict) ? sat_inc(mispred_cnt_q, STAT_MAX)
                                            : mispred_cnt_q;
  end

  // Statistics registers; clear does not touch them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector testbench for branch_predictor (defaults: 16 entries,
// 8-bit tag, 2-bit counters).
module tb_branch_predictor;

  localparam int DATA_W = 64;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              enable, clear;
  logic [DATA_W-1:0] lookup_pc;
  logic              pred_hit, pred_taken;
  logic [DATA_W-1:0] pred_target;
  logic              upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
  logic [DATA_W-1:0] upd_pc, upd_target, upd_pred_target;
  logic              mispredict;
  logic [DATA_W-1:0] redirect_pc;
  logic [31:0]       branch_cnt, mispred_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  branch_predictor #(
    .DATA_W  (DATA_W),
    .ENTRIES (16),
    .TAG_W   (8),
    .CNT_W   (2)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .enable          (enable),
    .clear           (clear),
    .lookup_pc       (lookup_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_is_jump     (upd_is_jump),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .branch_cnt      (branch_cnt),
    .mispred_cnt     (mispred_cnt)
  );

  typedef struct {
    logic        en, clr, uv, uj, ut, upt;
    logic [63:0] upc, utgt, uptgt, lpc;
    logic        eh, et, em;
    logic [63:0] etgt, erd;
  } vec_t;

  function automatic vec_t mk(logic en, logic clr, logic uv, logic uj, logic ut,
                              logic [63:0] upc, logic [63:0] utgt, logic upt,
                              logic [63:0] uptgt, logic [63:0] lpc, logic eh,
                              logic et, logic [63:0] etgt, logic em, logic [63:0] erd);
    vec_t v;
    v.en = en; v.clr = clr; v.uv = uv; v.uj = uj; v.ut = ut; v.upc = upc;
    v.utgt = utgt; v.upt = upt; v.uptgt = uptgt; v.lpc = lpc;
    v.eh = eh; v.et = et; v.etgt = etgt; v.em = em; v.erd = erd;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    enable = v.en; clear = v.clr; upd_valid = v.uv; upd_is_jump = v.uj;
    upd_taken = v.ut; upd_pc = v.upc; upd_target = v.utgt;
    upd_pred_taken = v.upt; upd_pred_target = v.uptgt; lookup_pc = v.lpc;
  endtask

  // Drive at posedge+1, compare at negedge, return at next posedge+1.
  task automatic apply_vec(string tag, vec_t v);
    drive(v);
    @(negedge clk_i);
    chk({tag, " pred_hit"},    64'(pred_hit),    64'(v.eh));
    chk({tag, " pred_taken"},  64'(pred_taken),  64'(v.et));
    chk({tag, " pred_target"}, pred_target,      v.etgt);
    chk({tag, " mispredict"},  64'(mispredict),  64'(v.em));
    chk({tag, " redirect_pc"}, redirect_pc,      v.erd);
    @(posedge clk_i);
    #1;
  endtask

  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  vec_t vecs[$];
  vec_t idle;

  initial begin
    // idx = pc[5:2], tag = pc[13:6]; 0x40 and 0x440 share index 0.
    vecs.push_back(mk(1,0,0,0,0, 0,      0,     0, 0,      'h40,  0,0,'h44,  0,'h4));
    vecs.push_back(mk(1,0,1,0,1, 'h40,   'h100, 0, 'h44,   'h40,  0,0,'h44,  1,'h100));
    vecs.push_back(mk(1,0,1,0,0, 'h40,   0,     1, 'h100,  'h40,  1,1,'h100, 1,'h44));
    vecs.push_back(mk(1,0,0,0,0, 0,      0,     0, 0,      'h40,  1,0,'h44,  0,'h4));
    vecs.push_back(mk(1,0,1,0,1, 'h40,   'h100, 0, 'h44,   'h40,  1,0,'h44,  1,'h100));
    vecs.push_back(mk(1,0,1,0,1, 'h40,   'h100, 1, 'h100,  'h40,  1,1,'h100, 0,'h100));
    vecs.push_back(mk(1,0,1,0,1, 'h40,   'h100, 1, 'h100,  'h40,  1,1,'h100, 0,'h100));
    vecs.push_back(mk(1,0,1,0,1, 'h40,   'h100, 1, 'h100,  'h40,  1,1,'h100, 0,'h100));
    vecs.push_back(mk(1,0,1,0,0, 'h40,   0,     1, 'h100,  'h40,  1,1,'h100, 1,'h44));
    vecs.push_back(mk(1,0,1,0,0, 'h40,   0,     1, 'h100,  'h40,  1,1,'h100, 1,'h44));
    vecs.push_back(mk(1,0,0,0,0, 0,      0,     0, 0,      'h40,  1,0,'h44,  0,'h4));
    vecs.push_back(mk(1,0,1,0,1, 'h440,  'h200, 0, 'h444,  'h440, 0,0,'h444, 1,'h200));
    vecs.push_back(mk(1,0,0,0,0, 0,      0,     0, 0,      'h40,  0,0,'h44,  0,'h4));
    vecs.push_back(mk(1,0,1,0,1, 'h84,   'h180, 1, 'h100,  'h440, 1,1,'h200, 1,'h180));
    vecs.push_back(mk(0,0,1,0,0, 'h84,   0,     1, 'h180,  'h84,  1,1,'h180, 1,'h88));
    vecs.push_back(mk(1,1,1,0,1, 'h84,   'h300, 1, 'h180,  'h84,  1,1,'h180, 1,'h300));
    vecs.push_back(mk(1,0,0,0,0, 0,      0,     0, 0,      'h84,  0,0,'h88,  0,'h4));
    vecs.push_back(mk(1,0,0,0,0, 0,      0,     0, 0,      'h440, 0,0,'h444, 0,'h4));
    vecs.push_back(mk(1,0,1,0,0, TOP,    0,     0, 0,      TOP,   0,0,0,     0,0));
    vecs.push_back(mk(1,0,1,1,1, 'h100,  'h500, 0, 'h104,  'h100, 0,0,'h104, 1,'h500));
    vecs.push_back(mk(1,0,0,0,0, 0,      0,     0, 0,      'h100, 1,1,'h500, 0,'h4));
    idle = mk(1,0,0,0,0, 0, 0, 0, 0, 'h40, 0,0,0, 0,0);

    // Reset state, checked while reset is held.
    rst_ni = 1'b0;
    drive(idle);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst pred_hit",    64'(pred_hit),   64'd0);
    chk("rst pred_taken",  64'(pred_taken), 64'd0);
    chk("rst pred_target", pred_target,     64'h44);
    chk("rst branch_cnt",  64'(branch_cnt), 64'd0);
    chk("rst mispred_cnt", 64'(mispred_cnt),64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < vecs.size(); i++) apply_vec($sformatf("v%0d", i), vecs[i]);

    // 13 enabled updates (v14 disabled), 9 of them mispredicted.
    chk("stat branch_cnt",  64'(branch_cnt),  64'd13);
    chk("stat mispred_cnt", 64'(mispred_cnt), 64'd9);

    // Stat counters pinned at all-ones must not wrap on a further mispredict.
    drive(idle);
    force dut.mispred_cnt_q = 32'hFFFF_FFFF;
    force dut.branch_cnt_q  = 32'hFFFF_FFFF;
    @(posedge clk_i);
    #1;
    release dut.mispred_cnt_q;
    release dut.branch_cnt_q;
    apply_vec("sat", mk(1,0,1,0,1, 'h200, 'h600, 0, 'h204, 'h200, 0,0,'h204, 1,'h600));
    chk("sat mispred_cnt", 64'(mispred_cnt), 64'hFFFF_FFFF);
    chk("sat branch_cnt",  64'(branch_cnt),  64'hFFFF_FFFF);

    // Reset asserted while an update is presented: update lost, state cleared.
    drive(mk(1,0,1,0,1, 'h40, 'h100, 0, 'h44, 'h200, 0,0,0, 0,0));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst branch_cnt",  64'(branch_cnt),  64'd0);
    chk("arst mispred_cnt", 64'(mispred_cnt), 64'd0);
    chk("arst hit_0x200",   64'(pred_hit),    64'd0);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    drive(idle);
    @(posedge clk_i);
    #1;
    chk("arst hit_0x40",    64'(pred_hit),    64'd0);
    chk("arst tgt_0x40",    pred_target,      64'h44);
    chk("arst branch_cnt2", 64'(branch_cnt),  64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
